// File: rtl/or1200_if_pfq_if.sv
// Bus, flush and IF-side signals of the instruction prefetch queue.
// The master modport is the queue itself; slave is the CPU bus plus IF environment.
interface or1200_if_pfq_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          icpu_cycstb_o;
  logic [31:0]   icpu_adr_o;
  logic          icpu_ack_i;
  logic          icpu_err_i;
  logic [31:0]   icpu_dat_i;
  logic [3:0]    icpu_tag_i;
  logic          flush_i;
  logic [31:0]   flush_adr_i;
  logic          pfq_valid_o;
  logic [31:0]   pfq_insn_o;
  logic [31:0]   pfq_adr_o;
  logic [2:0]    pfq_err_o;
  logic          if_take_i;
  logic [CW-1:0] pfq_count_o;

  modport master (
    output icpu_cycstb_o, icpu_adr_o,
    input  icpu_ack_i, icpu_err_i, icpu_dat_i, icpu_tag_i,
    input  flush_i, flush_adr_i,
    output pfq_valid_o, pfq_insn_o, pfq_adr_o, pfq_err_o, pfq_count_o,
    input  if_take_i
  );

  modport slave (
    input  icpu_cycstb_o, icpu_adr_o,
    output icpu_ack_i, icpu_err_i, icpu_dat_i, icpu_tag_i,
    output flush_i, flush_adr_i,
    input  pfq_valid_o, pfq_insn_o, pfq_adr_o, pfq_err_o, pfq_count_o,
    output if_take_i
  );
endinterface

// File: rtl/or1200_if_pfq.sv
// Instruction prefetch queue between the instruction bus and the IF stage:
// issues sequential single-beat fetches and buffers returned words with address and error flags.
module or1200_if_pfq #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0100,
  parameter logic [31:0] NOP_INSN  = {6'b000101, 26'h041_0000}
) (
  input  logic              clk,
  input  logic              rst,
  or1200_if_pfq_if.master   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic          halt_reg, halt_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          cyc_reg, cyc_next;
  logic [31:0]   adr_reg, adr_next;

  logic [31:0]   insn_mem [DEPTH];
  logic [31:0]   adr_mem  [DEPTH];
  logic [2:0]    err_mem  [DEPTH];

  logic          done;
  logic          pop;
  logic          push;
  logic          halt_upd;
  logic [CW:0]   cnt_nx;
  logic          can_issue;
  logic [2:0]    push_err;
  logic          head_valid;

  assign done       = bus.icpu_ack_i | bus.icpu_err_i;
  assign head_valid = (count_reg != '0);
  assign pop        = head_valid & bus.if_take_i;
  assign push       = done & (state_reg == REQ) & ~bus.flush_i;
  assign cnt_nx     = {1'b0, count_reg} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  // An errored fetch blocks the back-to-back request in the same cycle it returns.
  assign halt_upd   = halt_reg | (push & bus.icpu_err_i);
  assign can_issue  = ~halt_upd & ~bus.flush_i & (cnt_nx < DEPTH_W);

  assign push_err = {bus.icpu_err_i & (bus.icpu_tag_i == 4'hb),
                     bus.icpu_err_i & (bus.icpu_tag_i == 4'hc),
                     bus.icpu_err_i & (bus.icpu_tag_i == 4'hd)};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cyc_reg   <= 1'b0;
      adr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      adr_reg   <= adr_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (can_issue) state_next = REQ;
      REQ: begin
        if (bus.flush_i) begin
          // A request cannot be withdrawn once raised, so wait it out in DROP.
          state_next = done ? IDLE : DROP;
        end else if (done) begin
          state_next = can_issue ? REQ : IDLE;
        end
      end
      DROP: if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus request outputs
  always_comb begin
    cyc_next = (state_next != IDLE);
    adr_next = adr_reg;
    unique case (state_reg)
      IDLE: if (state_next == REQ) adr_next = fetch_pc_reg & WORD_MASK;
      REQ:  if (push && can_issue) adr_next = (fetch_pc_reg + 32'd4) & WORD_MASK;
      default: adr_next = adr_reg;
    endcase
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    halt_next     = halt_upd;
    count_next    = cnt_nx[CW-1:0];
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    if (bus.flush_i) begin
      fetch_pc_next = bus.flush_adr_i & WORD_MASK;
      halt_next     = 1'b0;
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
    end else begin
      if (push) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
        wr_ptr_next   = wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg <= RESET_VEC;
      halt_reg     <= 1'b0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      halt_reg     <= halt_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
    end
  end

  // Queue storage has no reset; occupancy is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem[wr_ptr_reg] <= bus.icpu_dat_i;
      adr_mem[wr_ptr_reg]  <= adr_reg & WORD_MASK;
      err_mem[wr_ptr_reg]  <= push_err;
    end
  end

  assign bus.icpu_cycstb_o = cyc_reg;
  assign bus.icpu_adr_o    = adr_reg;
  assign bus.pfq_valid_o   = head_valid;
  assign bus.pfq_insn_o    = head_valid ? insn_mem[rd_ptr_reg] : NOP_INSN;
  assign bus.pfq_adr_o     = head_valid ? adr_mem[rd_ptr_reg]  : 32'h0;
  assign bus.pfq_err_o     = head_valid ? err_mem[rd_ptr_reg]  : 3'b000;
  assign bus.pfq_count_o   = count_reg;

endmodule

// File: tb/tb_or1200_if_pfq.sv
// Scoreboard bench for or1200_if_pfq: bus responses push expected entries, IF takes pop and compare.
module tb_or1200_if_pfq;

  localparam logic [31:0] NOP = {6'b000101, 26'h041_0000};

  typedef struct {
    logic [31:0] insn;
    logic [31:0] adr;
    logic [2:0]  err;
  } entry_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  entry_t sb[$];

  or1200_if_pfq_if #(.DEPTH(4)) bus();

  or1200_if_pfq #(
    .DEPTH(4),
    .RESET_VEC(32'h0000_0100),
    .NOP_INSN(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [2:0] err_of(input logic is_err, input logic [3:0] tag);
    if (!is_err) return 3'b000;
    case (tag)
      4'hb: return 3'b100;
      4'hc: return 3'b010;
      4'hd: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.icpu_ack_i  = 1'b0;
    bus.icpu_err_i  = 1'b0;
    bus.icpu_dat_i  = 32'h0;
    bus.icpu_tag_i  = 4'h0;
    bus.flush_i     = 1'b0;
    bus.flush_adr_i = 32'h0;
    bus.if_take_i   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    sb.delete();
  endtask

  // Wait (bounded) for a request, check its address, respond, optionally take the head too.
  task automatic drive_ack(input logic [31:0] exp_adr, input logic is_err, input logic [3:0] tag,
                           input logic take, output int waited);
    entry_t e;
    waited = 0;
    while (bus.icpu_cycstb_o !== 1'b1 && waited < 20) begin
      cycle();
      waited++;
    end
    checks++;
    if (bus.icpu_cycstb_o !== 1'b1 || bus.icpu_adr_o !== exp_adr) begin
      errors++;
      $display("FAIL req_adr: got cyc=%b adr=%h, expected cyc=1 adr=%h", bus.icpu_cycstb_o, bus.icpu_adr_o, exp_adr);
    end
    if (take) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL take_head: scoreboard empty while taking, pfq_valid_o=%b", bus.pfq_valid_o);
      end else begin
        e = sb.pop_front();
        if (bus.pfq_valid_o !== 1'b1 || bus.pfq_insn_o !== e.insn || bus.pfq_adr_o !== e.adr || bus.pfq_err_o !== e.err) begin
          errors++;
          $display("FAIL take_head: got v=%b insn=%h adr=%h err=%b, expected v=1 insn=%h adr=%h err=%b",
                   bus.pfq_valid_o, bus.pfq_insn_o, bus.pfq_adr_o, bus.pfq_err_o, e.insn, e.adr, e.err);
        end
      end
    end
    bus.icpu_dat_i = insn_of(exp_adr);
    bus.icpu_ack_i = ~is_err;
    bus.icpu_err_i = is_err;
    bus.icpu_tag_i = tag;
    bus.if_take_i  = take;
    sb.push_back('{insn: insn_of(exp_adr), adr: exp_adr, err: err_of(is_err, tag)});
    $display("ack adr=%h err=%b tag=%h take=%b waited=%0d", exp_adr, is_err, tag, take, waited);
    cycle();
    idle_inputs();
  endtask

  task automatic drive_take();
    entry_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL take_head: scoreboard empty while taking, pfq_valid_o=%b", bus.pfq_valid_o);
    end else begin
      e = sb.pop_front();
      if (bus.pfq_valid_o !== 1'b1 || bus.pfq_insn_o !== e.insn || bus.pfq_adr_o !== e.adr || bus.pfq_err_o !== e.err) begin
        errors++;
        $display("FAIL take_head: got v=%b insn=%h adr=%h err=%b, expected v=1 insn=%h adr=%h err=%b",
                 bus.pfq_valid_o, bus.pfq_insn_o, bus.pfq_adr_o, bus.pfq_err_o, e.insn, e.adr, e.err);
      end
      $display("take adr=%h insn=%h err=%b", e.adr, e.insn, e.err);
    end
    bus.if_take_i = 1'b1;
    cycle();
    bus.if_take_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    cycle();
    cycle();
    checks++;
    if (bus.icpu_cycstb_o !== 1'b0 || bus.icpu_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got cyc=%b adr=%h, expected cyc=0 adr=0", bus.icpu_cycstb_o, bus.icpu_adr_o);
    end
    checks++;
    if (bus.pfq_valid_o !== 1'b0 || bus.pfq_insn_o !== NOP || bus.pfq_adr_o !== 32'h0 ||
        bus.pfq_err_o !== 3'b000 || bus.pfq_count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_head: got v=%b insn=%h adr=%h err=%b cnt=%0d, expected v=0 insn=%h adr=0 err=0 cnt=0",
               bus.pfq_valid_o, bus.pfq_insn_o, bus.pfq_adr_o, bus.pfq_err_o, bus.pfq_count_o, NOP);
    end
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic test_fill();
    int w;
    for (int i = 0; i < 4; i++) begin
      drive_ack(32'h100 + 32'(4 * i), 1'b0, 4'h0, 1'b0, w);
      if (i > 0) begin
        checks++;
        if (w != 0) begin
          errors++;
          $display("FAIL fill_back_to_back: got %0d idle cycles, expected 0", w);
        end
      end
    end
    checks++;
    if (bus.icpu_cycstb_o !== 1'b0 || bus.pfq_count_o !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: got cyc=%b cnt=%0d, expected cyc=0 cnt=4", bus.icpu_cycstb_o, bus.pfq_count_o);
    end
    checks++;
    if (bus.pfq_insn_o !== insn_of(32'h100) || bus.pfq_adr_o !== 32'h100) begin
      errors++;
      $display("FAIL fill_head: got insn=%h adr=%h, expected insn=%h adr=00000100",
               bus.pfq_insn_o, bus.pfq_adr_o, insn_of(32'h100));
    end
  endtask

  task automatic test_back_to_back();
    int w;
    drive_take();
    checks++;
    if (bus.icpu_cycstb_o !== 1'b1 || bus.icpu_adr_o !== 32'h110 || bus.pfq_count_o !== 3'd3) begin
      errors++;
      $display("FAIL refill_req: got cyc=%b adr=%h cnt=%0d, expected cyc=1 adr=00000110 cnt=3",
               bus.icpu_cycstb_o, bus.icpu_adr_o, bus.pfq_count_o);
    end
    drive_ack(32'h110, 1'b0, 4'h0, 1'b1, w);
    checks++;
    if (bus.pfq_count_o !== 3'd3 || bus.icpu_cycstb_o !== 1'b1 || bus.icpu_adr_o !== 32'h114) begin
      errors++;
      $display("FAIL push_pop: got cnt=%0d cyc=%b adr=%h, expected cnt=3 cyc=1 adr=00000114",
               bus.pfq_count_o, bus.icpu_cycstb_o, bus.icpu_adr_o);
    end
    drive_ack(32'h114, 1'b0, 4'h0, 1'b0, w);
    checks++;
    if (bus.pfq_count_o !== 3'd4 || bus.icpu_cycstb_o !== 1'b0) begin
      errors++;
      $display("FAIL refull: got cnt=%0d cyc=%b, expected cnt=4 cyc=0", bus.pfq_count_o, bus.icpu_cycstb_o);
    end
    for (int i = 0; i < 4; i++) drive_take();
    checks++;
    if (bus.pfq_count_o !== 3'd0 || bus.pfq_valid_o !== 1'b0 || bus.pfq_insn_o !== NOP) begin
      errors++;
      $display("FAIL drain_empty: got cnt=%0d v=%b insn=%h, expected cnt=0 v=0 insn=%h",
               bus.pfq_count_o, bus.pfq_valid_o, bus.pfq_insn_o, NOP);
    end
  endtask

  task automatic test_flush_drop();
    int w;
    do_reset();
    drive_ack(32'h100, 1'b0, 4'h0, 1'b0, w);
    drive_ack(32'h104, 1'b0, 4'h0, 1'b0, w);
    bus.flush_i     = 1'b1;
    bus.flush_adr_i = 32'h2003;
    cycle();
    idle_inputs();
    sb.delete();
    checks++;
    if (bus.pfq_count_o !== 3'd0 || bus.pfq_valid_o !== 1'b0 || bus.pfq_insn_o !== NOP || bus.icpu_cycstb_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_drop: got cnt=%0d v=%b insn=%h cyc=%b, expected cnt=0 v=0 insn=%h cyc=1",
               bus.pfq_count_o, bus.pfq_valid_o, bus.pfq_insn_o, bus.icpu_cycstb_o, NOP);
    end
    cycle();
    cycle();
    bus.icpu_ack_i = 1'b1;
    bus.icpu_dat_i = 32'hDEAD_BEEF;
    cycle();
    idle_inputs();
    checks++;
    if (bus.icpu_cycstb_o !== 1'b0 || bus.pfq_count_o !== 3'd0) begin
      errors++;
      $display("FAIL drop_discard: got cyc=%b cnt=%0d, expected cyc=0 cnt=0", bus.icpu_cycstb_o, bus.pfq_count_o);
    end
    drive_ack(32'h2000, 1'b0, 4'h0, 1'b0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL flush_restart: got %0d idle cycles, expected 1", w);
    end
  endtask

  task automatic test_error();
    int w;
    do_reset();
    drive_ack(32'h100, 1'b0, 4'h0, 1'b0, w);
    drive_ack(32'h104, 1'b1, 4'hc, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.icpu_cycstb_o !== 1'b0 || bus.pfq_count_o !== 3'd2) begin
        errors++;
        $display("FAIL err_halt: got cyc=%b cnt=%0d, expected cyc=0 cnt=2", bus.icpu_cycstb_o, bus.pfq_count_o);
      end
      cycle();
    end
    drive_take();
    drive_take();
    checks++;
    if (bus.icpu_cycstb_o !== 1'b0 || bus.pfq_count_o !== 3'd0) begin
      errors++;
      $display("FAIL err_drain: got cyc=%b cnt=%0d, expected cyc=0 cnt=0", bus.icpu_cycstb_o, bus.pfq_count_o);
    end
    bus.flush_i     = 1'b1;
    bus.flush_adr_i = 32'h3000;
    cycle();
    idle_inputs();
    drive_ack(32'h3000, 1'b0, 4'h0, 1'b0, w);
  endtask

  task automatic test_flush_ack();
    bus.flush_i     = 1'b1;
    bus.flush_adr_i = 32'h4000;
    bus.icpu_ack_i  = 1'b1;
    bus.icpu_dat_i  = insn_of(32'h3004);
    cycle();
    idle_inputs();
    sb.delete();
    checks++;
    if (bus.icpu_cycstb_o !== 1'b0 || bus.pfq_count_o !== 3'd0) begin
      errors++;
      $display("FAIL flush_ack_idle: got cyc=%b cnt=%0d, expected cyc=0 cnt=0", bus.icpu_cycstb_o, bus.pfq_count_o);
    end
    cycle();
    checks++;
    if (bus.icpu_cycstb_o !== 1'b1 || bus.icpu_adr_o !== 32'h4000) begin
      errors++;
      $display("FAIL flush_ack_resume: got cyc=%b adr=%h, expected cyc=1 adr=00004000", bus.icpu_cycstb_o, bus.icpu_adr_o);
    end
  endtask

  task automatic test_err_tags();
    logic [3:0]  tags  [3];
    logic [31:0] bases [3];
    int w;
    tags[0] = 4'hb; tags[1] = 4'hd; tags[2] = 4'h5;
    bases[0] = 32'h100; bases[1] = 32'h5000; bases[2] = 32'h6000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        bus.flush_i     = 1'b1;
        bus.flush_adr_i = bases[i] | 32'h1;
        cycle();
        idle_inputs();
      end
      drive_ack(bases[i], 1'b1, tags[i], 1'b0, w);
      checks++;
      if (bus.icpu_cycstb_o !== 1'b0 || bus.pfq_count_o !== 3'd1) begin
        errors++;
        $display("FAIL tag_halt: got cyc=%b cnt=%0d, expected cyc=0 cnt=1 (tag %h)", bus.icpu_cycstb_o, bus.pfq_count_o, tags[i]);
      end
      drive_take();
    end
  endtask

  task automatic test_reset_mid();
    int w;
    bus.flush_i     = 1'b1;
    bus.flush_adr_i = 32'h7000;
    cycle();
    idle_inputs();
    drive_ack(32'h7000, 1'b0, 4'h0, 1'b0, w);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.icpu_cycstb_o !== 1'b0 || bus.pfq_valid_o !== 1'b0 || bus.pfq_insn_o !== NOP || bus.pfq_count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: got cyc=%b v=%b insn=%h cnt=%0d, expected cyc=0 v=0 insn=%h cnt=0",
               bus.icpu_cycstb_o, bus.pfq_valid_o, bus.pfq_insn_o, bus.pfq_count_o, NOP);
    end
    cycle();
    rst = 1'b1;
    sb.delete();
    drive_ack(32'h100, 1'b0, 4'h0, 1'b0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL reset_restart: got %0d idle cycles, expected 1", w);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_flush_drop();
    test_error();
    test_flush_ack();
    test_err_tags();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
